hvac_sequencer: RTL
===================

HVAC_SEQUENCER -- requirements
Module: hvac_sequencer

Interface
REQ-001 SHALL have parameter FAN_LEAD, default 2: cycles the fan runs before the heater or cooler is enabled (legal range >=1).
REQ-002 SHALL have parameter FAN_LAG, default 3: cycles the fan keeps running after the heater or cooler is released (>=1).
REQ-003 SHALL have parameter MIN_ON, default 4: minimum number of cycles heat_en or cool_en stays high once asserted (>=1).
REQ-004 SHALL have parameter MIN_OFF, default 5: lockout cycles with all outputs low before a new run may start (>=1).
REQ-005 SHALL have parameter TW, default 8: timer width; every timing parameter SHALL fit in TW bits.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state updates occur on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port mode_req, input, 2 bits: thermostat request; 00 = off, 10 = heat, 01 = cool, 11 = treated as off.
REQ-009 SHALL have port estop, input, 1 bit: emergency stop, sampled synchronously, active-high.
REQ-010 SHALL have port heat_en, output, 1 bit: heater enable.
REQ-011 SHALL have port cool_en, output, 1 bit: cooler enable.
REQ-012 SHALL have port fan_en, output, 1 bit: fan enable.
REQ-013 SHALL have port sts, output, 3 bits: current state code per REQ-015.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE=0, FAN_PRE=1, HEAT=2, COOL=3, FAN_POST=4, LOCKOUT=5; codes 6 and 7 SHALL return to IDLE on the next edge.
REQ-016 SHALL be Moore: all outputs are decoded from the registered state only, with no combinational path from inputs to outputs.
REQ-017 SHALL drive outputs per state:
- fan_en high in FAN_PRE, HEAT, COOL and FAN_POST.
- heat_en high only in HEAT.
- cool_en high only in COOL.
- heat_en and cool_en SHALL never be high together.
REQ-018 SHALL use one TW-bit timer that clears to 0 on every state change and increments each cycle while in the same state, saturating at its maximum value.
REQ-019 IDLE: mode_req of heat or cool SHALL latch that request as the target and move to FAN_PRE on the same edge; off or 11 SHALL stay in IDLE.
REQ-020 FAN_PRE:
- mode_req heat or cool SHALL overwrite the latched target each cycle.
- mode_req off SHALL move to IDLE.
- otherwise, when timer == FAN_LEAD-1, SHALL move to HEAT or COOL according to the latched target.
REQ-021 HEAT:
- exit to FAN_POST only when timer >= MIN_ON-1 and mode_req != 10.
- a request for cool SHALL exit to FAN_POST, never directly to COOL.
REQ-022 COOL SHALL behave as REQ-021 with 01 in place of 10.
REQ-023 FAN_POST SHALL move to LOCKOUT when timer == FAN_LAG-1; mode_req SHALL be ignored in this state.
REQ-024 LOCKOUT SHALL move to IDLE when timer == MIN_OFF-1; mode_req SHALL be ignored in this state.
REQ-025 estop high at an edge SHALL force the next state to LOCKOUT from any state except IDLE, overriding MIN_ON.
REQ-026 While estop stays high in LOCKOUT, the timer SHALL be held at 0, so MIN_OFF counts from estop deassertion.
REQ-027 estop high in IDLE SHALL keep the block in IDLE and block new requests.
REQ-028 Latency: a request sampled at edge k SHALL give fan_en high after edge k, and heat_en or cool_en high after edge k+FAN_LEAD.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) set state to IDLE, timer to 0 and the latched target to off, forcing heat_en, cool_en and fan_en to 0, sts to 0 and busy to 0.
REQ-030 Assertion of rst_n mid-run, including in HEAT or COOL before MIN_ON has elapsed, SHALL drop all enables at once with no FAN_POST or LOCKOUT.
REQ-031 Release of rst_n SHALL take effect at the first rising edge of clk with rst_n high.

Verification (default parameters)
REQ-032 Reset release, mode_req=10 held -> fan_en high 1 cycle after sampling; heat_en high 2 cycles later; sts 0->1->2.
REQ-033 In HEAT, mode_req=00 after 1 cycle -> heat_en high exactly 4 cycles total; then fan_en only for 3 cycles; then 5 cycles of all-low with busy=1; then IDLE.
REQ-034 In COOL, mode_req switched to 10 -> sequence COOL, FAN_POST, LOCKOUT, IDLE, FAN_PRE, HEAT; heat_en and cool_en never overlap.
REQ-035 estop pulsed 1 cycle during HEAT timer=1 -> heat_en and fan_en low next cycle; sts=5 for 5 cycles; then IDLE.
REQ-036 mode_req=10 for 1 cycle, then 00 -> FAN_PRE then IDLE; heat_en never asserted.
REQ-037 rst_n pulsed low mid-HEAT, asynchronous to clk -> all outputs 0 before the next clk edge; sts=0.

Source files
------------

// File: rtl/hvac_sequencer.sv
// HVAC run sequencer: fan pre-run, heat or cool with minimum on-time,
// fan post-run, then an all-off lockout before a new run may start.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | all off, waiting for a heat or cool request
// FAN_PRE  | fan only, purging ahead of the heater/cooler
// HEAT     | heater and fan on, held for at least MIN_ON cycles
// COOL     | cooler and fan on, held for at least MIN_ON cycles
// FAN_POST | fan only, clearing residual heat/cold
// LOCKOUT  | all off, short-cycle protection (MIN_OFF cycles)
module hvac_sequencer #(
   parameter int FAN_LEAD = 2,
   parameter int FAN_LAG  = 3,
   parameter int MIN_ON   = 4,
   parameter int MIN_OFF  = 5,
   parameter int TW       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode_req,
   input  logic       estop,
   output logic       heat_en,
   output logic       cool_en,
   output logic       fan_en,
   output logic [2:0] sts,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FAN_PRE  = 3'd1,
      S_HEAT     = 3'd2,
      S_COOL     = 3'd3,
      S_FAN_POST = 3'd4,
      S_LOCKOUT  = 3'd5
   } state_t;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_HEAT = 2'b10;
   localparam logic [1:0] MODE_COOL = 2'b01;

   localparam logic [TW-1:0] LEAD_TC = TW'(FAN_LEAD - 1);
   localparam logic [TW-1:0] LAG_TC  = TW'(FAN_LAG - 1);
   localparam logic [TW-1:0] ON_TC   = TW'(MIN_ON - 1);
   localparam logic [TW-1:0] OFF_TC  = TW'(MIN_OFF - 1);

   state_t          state, state_nxt;
   logic [TW-1:0]   timer;
   logic [1:0]      target, target_nxt;
   logic            req_valid;
   logic            timer_hold;

   assign req_valid  = (mode_req == MODE_HEAT) || (mode_req == MODE_COOL);
   // Holding the timer at zero during estop makes MIN_OFF count from release.
   assign timer_hold = (state == S_LOCKOUT) && estop;

   // State and latched target registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         target <= MODE_OFF;
      end else begin
         state  <= state_nxt;
         target <= target_nxt;
      end
   end

   // Per-state timer: clears on any state change, saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if ((state_nxt != state) || timer_hold) begin
         timer <= '0;
      end else if (timer != '1) begin
         timer <= timer + 1'b1;
      end
   end

   // Next-state and target selection.
   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      case (state)
         S_IDLE: begin
            if (!estop && req_valid) begin
               target_nxt = mode_req;
               state_nxt  = S_FAN_PRE;
            end
         end
         S_FAN_PRE: begin
            if (estop) begin
               state_nxt = S_LOCKOUT;
            end else if (!req_valid) begin
               state_nxt = S_IDLE;
            end else begin
               target_nxt = mode_req;
               if (timer == LEAD_TC)
                  state_nxt = (mode_req == MODE_HEAT) ? S_HEAT : S_COOL;
            end
         end
         S_HEAT: begin
            if (estop)
               state_nxt = S_LOCKOUT;
            else if ((timer >= ON_TC) && (mode_req != MODE_HEAT))
               state_nxt = S_FAN_POST;
         end
         S_COOL: begin
            if (estop)
               state_nxt = S_LOCKOUT;
            else if ((timer >= ON_TC) && (mode_req != MODE_COOL))
               state_nxt = S_FAN_POST;
         end
         S_FAN_POST: begin
            if (estop || (timer == LAG_TC))
               state_nxt = S_LOCKOUT;
         end
         S_LOCKOUT: begin
            if (!estop && (timer == OFF_TC))
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore output decode from the registered state only.
   always_comb begin
      heat_en = 1'b0;
      cool_en = 1'b0;
      fan_en  = 1'b0;
      case (state)
         S_FAN_PRE:  fan_en = 1'b1;
         S_HEAT:     begin heat_en = 1'b1; fan_en = 1'b1; end
         S_COOL:     begin cool_en = 1'b1; fan_en = 1'b1; end
         S_FAN_POST: fan_en = 1'b1;
         default:    ;
      endcase
   end

   assign sts  = state;
   assign busy = (state != S_IDLE);

endmodule
